ctrl_mode_sequencer: RTL and testbench
======================================

Name: ctrl_mode_sequencer

Overview:
Parametrised stage sequencer and mode decoder for the dual-mode DNN datapath control path. It generates the read-stage count itself, instead of receiving it from an external counter. It produces NUM_MODES registered mode strobes per stage from a runtime-programmable table, replacing per-signal hand-derived decode blocks. Runs a layer as layer_repeat passes over NUM_STAGES stages, with a start/busy/done handshake and a stall input.

Parameters:
STAGE_W, 4, width of rd_stage; NUM_STAGES must be <= 2**STAGE_W
NUM_STAGES, 11, stages per pass (0..NUM_STAGES-1)
NUM_MODES, 4, number of mode output bits (one per controlled datapath mux/register)
REPEAT_W, 8, width of the pass-count fields

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  start request; sampled only in IDLE
layer_repeat  in  REPEAT_W  number of passes; latched on accepted start
stall  in  1  freeze sequencer while high (RUN only)
cfg_we  in  1  mode-table write enable
cfg_stage  in  STAGE_W  table row to write
cfg_modes  in  NUM_MODES  mode bits for that row
cfg_hold  in  NUM_MODES  hold mask for that row (used only with CTRL_SEQ_HOLD_EN)
rd_stage  out  STAGE_W  current stage, registered
mode  out  NUM_MODES  mode bits for current stage, registered
pass_cnt  out  REPEAT_W  current pass index, registered
busy  out  1  high in RUN
done  out  1  one-cycle pulse at end of layer

Behaviour:
- Reset: state=IDLE.
- Reset: rd_stage=0, mode=0, pass_cnt=0, busy=0, done=0.
- Reset: all table rows cleared (modes=0, hold=0).
- Reset asserted mid-RUN aborts the layer on the next edge; no done pulse is generated.
- FSM states: IDLE, RUN.
- IDLE, start=1, layer_repeat>0:
  - next edge: RUN, busy=1, rd_stage=0, pass_cnt=0, mode=table[0].
  - latch layer_repeat into rep_q.
- IDLE, start=1, layer_repeat=0: done=1 for one cycle; stay IDLE; outputs otherwise unchanged.
- RUN, stall=1: rd_stage, mode, pass_cnt and state all hold.
- RUN, stall=0, rd_stage<NUM_STAGES-1: rd_stage+1; mode=table[rd_stage+1], updated on the same edge as rd_stage.
- RUN, stall=0, rd_stage=NUM_STAGES-1, pass_cnt<rep_q-1: rd_stage=0, pass_cnt+1, mode=table[0].
- RUN, stall=0, rd_stage=NUM_STAGES-1, pass_cnt=rep_q-1:
  - next edge: IDLE, busy=0, done=1 for one cycle.
  - rd_stage=0, pass_cnt=0, mode=0.
- Latency: rd_stage/mode are valid the cycle after the accepting edge. A full layer takes rep_q*NUM_STAGES active (non-stalled) cycles in RUN.
- start during RUN: ignored. layer_repeat changes during RUN: ignored.
- start on the done-pulse cycle (state already IDLE): accepted normally, giving back-to-back layers.
- Table writes (cfg_we=1) are honoured only in IDLE.
- Table writes with cfg_stage>=NUM_STAGES are dropped.
- Table writes while busy are dropped; there is no error flag.
- A write and a start in the same IDLE cycle: the write lands first, so a write to row 0 is visible in mode on entry to RUN.
- Arithmetic: pass_cnt and rep_q are unsigned REPEAT_W; rep_q-1 cannot underflow because 0 is rejected at start. rd_stage is unsigned and never exceeds NUM_STAGES-1.

Optional Feature:
Macro CTRL_SEQ_HOLD_EN.
- Defined:
  - each table row also stores cfg_hold.
  - on a stage advance, mode bits whose hold bit is set in the new row keep their previous value; other bits load from the table.
  - this implements don't-care stages without glitching the controlled datapath.
  - on entry to RUN, held bits start from 0.
- Undefined:
  - cfg_hold is ignored and no hold storage is synthesised.
  - mode always equals table[rd_stage].

Decomposition:
- Shared package ctrl_seq_pkg holds:
  - state enum (IDLE, RUN).
  - localparam mode-bit indices (e.g. MODE_SSHRIN=0) used by the datapath.
  - default table constants for bench and bring-up.
- One sub-module, ctrl_mode_table: NUM_STAGES x NUM_MODES register file with a write port and a combinational read port; plus hold storage under CTRL_SEQ_HOLD_EN.
- FSM, counters and output registers stay in the top module.

Test Plan:
- Program row 7 and row 10 modes=4'b0001, row 6 and row 9 modes=4'b0000; start, layer_repeat=1, no stall.
  - mode[0] is 1 exactly while rd_stage=7 and rd_stage=10.
  - done pulses one cycle after rd_stage=10; busy is high for 11 cycles.
- layer_repeat=3: rd_stage wraps 10->0 twice; pass_cnt steps 0,1,2; done at active cycle 33; final pass_cnt=0 and mode=0.
- Stall held for 5 cycles at rd_stage=4:
  - rd_stage, mode and pass_cnt frozen; done delayed by exactly 5 cycles.
  - start pulsed during the stall is ignored.
- start with layer_repeat=0 -> single-cycle done, busy stays 0.
- cfg_we during RUN, or with cfg_stage=12 -> table unchanged: a re-run gives an identical mode trace.
- rst asserted at rd_stage=5, pass 1 -> next cycle all outputs 0, no done pulse, table cleared.
- With CTRL_SEQ_HOLD_EN: row 8 hold=4'b0001 -> mode[0] at stage 8 equals its stage-7 value.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the DNN datapath stage sequencer.
// Mode-bit indices and a bring-up default table live here for the datapath and bench.
package ctrl_seq_pkg;

  typedef enum logic {
    StIdle,
    StRun
  } seq_state_e;

  localparam int unsigned MODE_SSHRIN = 0;
  localparam int unsigned MODE_WSHRIN = 1;
  localparam int unsigned MODE_ACCCLR = 2;
  localparam int unsigned MODE_OUTEN  = 3;

  localparam int unsigned DEF_NUM_STAGES = 11;
  localparam int unsigned DEF_NUM_MODES  = 4;

  // Row 10 first, row 0 last.
  localparam logic [DEF_NUM_STAGES-1:0][DEF_NUM_MODES-1:0] DEF_MODE_TABLE = {
    4'b1001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000,
    4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0100
  };
  localparam logic [DEF_NUM_STAGES-1:0][DEF_NUM_MODES-1:0] DEF_HOLD_TABLE = '0;

endpackage

// File: rtl/ctrl_mode_table.sv
// Per-stage mode register file: one write port, one combinational read port.
// Hold-mask storage is built only when CTRL_SEQ_HOLD_EN is defined.
module ctrl_mode_table
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 11,
  parameter int unsigned STAGE_W    = 4,
  parameter int unsigned NUM_MODES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [STAGE_W-1:0]   wr_addr,
  input  logic [NUM_MODES-1:0] wr_modes,
  input  logic [NUM_MODES-1:0] wr_hold,
  input  logic [STAGE_W-1:0]   rd_addr,
  output logic [NUM_MODES-1:0] rd_modes,
  output logic [NUM_MODES-1:0] rd_hold
);

  logic [NUM_MODES-1:0] modes_q [NUM_STAGES];

  // Rows beyond NUM_STAGES have no match, so such writes fall away.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_STAGES); r++) modes_q[r] <= '0;
    end else if (wr_en) begin
      for (int r = 0; r < int'(NUM_STAGES); r++) begin
        if (wr_addr == STAGE_W'(r)) modes_q[r] <= wr_modes;
      end
    end
  end

  // Same-cycle write is forwarded so a start sees a fresh row 0.
  always_comb begin
    rd_modes = '0;
    for (int r = 0; r < int'(NUM_STAGES); r++) begin
      if (rd_addr == STAGE_W'(r)) rd_modes = modes_q[r];
    end
    if (wr_en && (wr_addr == rd_addr)) rd_modes = wr_modes;
  end

`ifdef CTRL_SEQ_HOLD_EN
  logic [NUM_MODES-1:0] hold_q [NUM_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_STAGES); r++) hold_q[r] <= '0;
    end else if (wr_en) begin
      for (int r = 0; r < int'(NUM_STAGES); r++) begin
        if (wr_addr == STAGE_W'(r)) hold_q[r] <= wr_hold;
      end
    end
  end

  always_comb begin
    rd_hold = '0;
    for (int r = 0; r < int'(NUM_STAGES); r++) begin
      if (rd_addr == STAGE_W'(r)) rd_hold = hold_q[r];
    end
    if (wr_en && (wr_addr == rd_addr)) rd_hold = wr_hold;
  end
`else
  logic unused_wr_hold;
  assign unused_wr_hold = ^wr_hold;
  assign rd_hold        = '0;
`endif

endmodule

// File: rtl/ctrl_mode_sequencer.sv
// Stage sequencer and mode decoder: runs layer_repeat passes over NUM_STAGES stages.
// Define CTRL_SEQ_HOLD_EN to let table rows hold selected mode bits across a stage advance.
module ctrl_mode_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned STAGE_W    = 4,
  parameter int unsigned NUM_STAGES = 11,
  parameter int unsigned NUM_MODES  = 4,
  parameter int unsigned REPEAT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [REPEAT_W-1:0]  layer_repeat,
  input  logic                 stall,
  input  logic                 cfg_we,
  input  logic [STAGE_W-1:0]   cfg_stage,
  input  logic [NUM_MODES-1:0] cfg_modes,
  input  logic [NUM_MODES-1:0] cfg_hold,
  output logic [STAGE_W-1:0]   rd_stage,
  output logic [NUM_MODES-1:0] mode,
  output logic [REPEAT_W-1:0]  pass_cnt,
  output logic                 busy,
  output logic                 done
);

  seq_state_e           state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [REPEAT_W-1:0]  pass_q, pass_d;
  logic [REPEAT_W-1:0]  rep_q, rep_d;
  logic [NUM_MODES-1:0] mode_q, mode_d;
  logic                 done_q, done_d;

  logic                 last_stage, last_pass;
  logic [STAGE_W-1:0]   tbl_addr;
  logic [NUM_MODES-1:0] tbl_modes, tbl_hold, tbl_merged;

  assign last_stage = (stage_q == STAGE_W'(NUM_STAGES - 1));
  assign last_pass  = (pass_q == rep_q - REPEAT_W'(1));

  // Look ahead to the row the next advance will load.
  assign tbl_addr = ((state_q == StRun) && !last_stage) ? stage_q + STAGE_W'(1) : '0;

  ctrl_mode_table #(
    .NUM_STAGES(NUM_STAGES),
    .STAGE_W   (STAGE_W),
    .NUM_MODES (NUM_MODES)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_we && (state_q == StIdle)),
    .wr_addr (cfg_stage),
    .wr_modes(cfg_modes),
    .wr_hold (cfg_hold),
    .rd_addr (tbl_addr),
    .rd_modes(tbl_modes),
    .rd_hold (tbl_hold)
  );

  assign tbl_merged = (mode_q & tbl_hold) | (tbl_modes & ~tbl_hold);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pass_d  = pass_q;
    rep_d   = rep_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (layer_repeat != '0) begin
            state_d = StRun;
            stage_d = '0;
            pass_d  = '0;
            rep_d   = layer_repeat;
            mode_d  = tbl_modes & ~tbl_hold;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (!stall) begin
          if (!last_stage) begin
            stage_d = stage_q + STAGE_W'(1);
            mode_d  = tbl_merged;
          end else if (!last_pass) begin
            stage_d = '0;
            pass_d  = pass_q + REPEAT_W'(1);
            mode_d  = tbl_merged;
          end else begin
            state_d = StIdle;
            stage_d = '0;
            pass_d  = '0;
            mode_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      pass_q  <= '0;
      rep_q   <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pass_q  <= pass_d;
      rep_q   <= rep_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign rd_stage = stage_q;
  assign mode     = mode_q;
  assign pass_cnt = pass_q;
  assign busy     = (state_q == StRun);
  assign done     = done_q;

endmodule

// File: tb/tb_ctrl_mode_sequencer.sv
// Directed bench for ctrl_mode_sequencer in its default build.
module tb_ctrl_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stall, cfg_we;
  logic [7:0] layer_repeat;
  logic [3:0] cfg_stage, cfg_modes, cfg_hold;
  logic [3:0] rd_stage, mode;
  logic [7:0] pass_cnt;
  logic       busy, done;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  ctrl_mode_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .layer_repeat(layer_repeat),
    .stall       (stall),
    .cfg_we      (cfg_we),
    .cfg_stage   (cfg_stage),
    .cfg_modes   (cfg_modes),
    .cfg_hold    (cfg_hold),
    .rd_stage    (rd_stage),
    .mode        (mode),
    .pass_cnt    (pass_cnt),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int stg, input int md, input int ps,
                         input int bsy, input int dn);
    chk({tag, "_stage"}, 32'(rd_stage), stg);
    chk({tag, "_mode"}, 32'(mode), md);
    chk({tag, "_pass"}, 32'(pass_cnt), ps);
    chk({tag, "_busy"}, 32'(busy), bsy);
    chk({tag, "_done"}, 32'(done), dn);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [3:0] row, input logic [3:0] modes);
    cfg_we    = 1'b1;
    cfg_stage = row;
    cfg_modes = modes;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Table contents after rows 0, 6, 7, 9, 10 have been programmed.
  function automatic int trace_mode(input int s, input int row0);
    if (s == 0) return row0;
    return (s == 7 || s == 10) ? 1 : 0;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; cfg_we = 1'b0;
    layer_repeat = 8'd0; cfg_stage = 4'd0; cfg_modes = 4'd0; cfg_hold = 4'd0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Single pass decode trace.
    write_row(4'd7, 4'b0001);
    write_row(4'd10, 4'b0001);
    write_row(4'd6, 4'b0000);
    write_row(4'd9, 4'b0000);
    start = 1'b1; layer_repeat = 8'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk_all($sformatf("t1_k%0d", k), k, trace_mode(k, 0), 0, 1, 0);
      tick();
    end
    chk_all("t1_done", 0, 0, 0, 0, 1);
    tick();
    chk("t1_done_clr", 32'(done), 0);

    // Three passes, with a row-0 write landing on the start cycle.
    cfg_we = 1'b1; cfg_stage = 4'd0; cfg_modes = 4'b1000;
    start = 1'b1; layer_repeat = 8'd3;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    for (int k = 0; k < 33; k++) begin
      chk_all($sformatf("t2_k%0d", k), k % 11, trace_mode(k % 11, 8), k / 11, 1, 0);
      tick();
    end
    chk_all("t2_done", 0, 0, 0, 0, 1);
    tick();

    // Five-cycle stall at stage 4 with an ignored start.
    start = 1'b1; layer_repeat = 8'd1;
    tick();
    start = 1'b0;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      cyc++;
    end
    chk_all("t3_pre", 4, 0, 0, 1, 0);
    stall = 1'b1; start = 1'b1; layer_repeat = 8'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      cyc++;
      chk_all($sformatf("t3_stall%0d", i), 4, 0, 0, 1, 0);
    end
    stall = 1'b0; start = 1'b0; layer_repeat = 8'd1;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t3_done_cycle", 32'(cyc), 16);
    chk_all("t3_done", 0, 0, 0, 0, 1);
    tick();

    // Zero repeat count: done pulse only.
    start = 1'b1; layer_repeat = 8'd0;
    tick();
    start = 1'b0;
    chk_all("t4", 0, 0, 0, 0, 1);
    tick();
    chk_all("t4_after", 0, 0, 0, 0, 0);

    // Dropped writes: out-of-range row and writes during RUN.
    write_row(4'd12, 4'b1111);
    start = 1'b1; layer_repeat = 8'd1;
    tick();
    start = 1'b0;
    cfg_we = 1'b1; cfg_stage = 4'd3; cfg_modes = 4'b1111;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("t5a_mode_k%0d", k), 32'(mode), trace_mode(k, 8));
      if (k == 9) cfg_we = 1'b0;
      tick();
    end
    chk("t5a_done", 32'(done), 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("t5b_mode_k%0d", k), 32'(mode), trace_mode(k, 8));
      tick();
    end
    chk("t5b_done", 32'(done), 1);
    tick();

    // Reset at stage 5 of pass 1.
    start = 1'b1; layer_repeat = 8'd2;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    chk_all("t6_pre", 5, 0, 1, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("t6_rst", 0, 0, 0, 0, 0);
    tick();
    chk_all("t6_after", 0, 0, 0, 0, 0);
    start = 1'b1; layer_repeat = 8'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      chk_all($sformatf("t6_clr_k%0d", k), k, 0, 0, 1, 0);
      tick();
    end
    chk("t6_done", 32'(done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
